main_cpu: RTL and testbench

//   8-bit single-cycle accumulator/register CPU core, instantiated by the top-level board as `main`.

---
 rtl/main_cpu_pkg.sv | 51 +++++
 rtl/main_cpu_if.sv | 27 ++
 rtl/main_cpu_alu.sv | 72 +++++++
 rtl/main_cpu.sv | 104 ++++++++++
 tb/tb_main_cpu.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/main_cpu_pkg.sv
// Shared constants for the main_cpu core: widths, opcodes, OUT2 bit positions
// and instruction field extraction helpers.
package main_cpu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned REG_AW   = 2;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned ICOUNT_W = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI1 = 4'h1;
  localparam logic [OP_W-1:0] OP_LDI2 = 4'h2;
  localparam logic [OP_W-1:0] OP_MOV  = 4'h3;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h4;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h5;
  localparam logic [OP_W-1:0] OP_AND  = 4'h6;
  localparam logic [OP_W-1:0] OP_OR   = 4'h7;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h8;
  localparam logic [OP_W-1:0] OP_NOT  = 4'h9;
  localparam logic [OP_W-1:0] OP_SHL  = 4'hA;
  localparam logic [OP_W-1:0] OP_SHR  = 4'hB;
  localparam logic [OP_W-1:0] OP_INC  = 4'hC;
  localparam logic [OP_W-1:0] OP_DEC  = 4'hD;
  localparam logic [OP_W-1:0] OP_OUT  = 4'hE;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  // Bit positions inside the OUT2 status byte; icount fills [ICOUNT_W-1:0].
  localparam int unsigned FLAG_HALT = 7;
  localparam int unsigned FLAG_Z    = 6;
  localparam int unsigned FLAG_N    = 5;
  localparam int unsigned FLAG_C    = 4;

  function automatic logic [OP_W-1:0] f_opcode(input logic [DATA_W-1:0] instr);
    return instr[7:4];
  endfunction

  function automatic logic [REG_AW-1:0] f_rd(input logic [DATA_W-1:0] instr);
    return instr[3:2];
  endfunction

  function automatic logic [REG_AW-1:0] f_rs(input logic [DATA_W-1:0] instr);
    return instr[1:0];
  endfunction

  // Opcodes 1..D write a register (and therefore update Z/N).
  function automatic logic f_writes_reg(input logic [OP_W-1:0] op);
    return (op != OP_NOP) && (op != OP_OUT) && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/main_cpu_if.sv
// Bus bundle for main_cpu: instruction/data inputs and the three output bytes.
//   IN0  instruction {opcode, rd, rs}
//   IN1  data input A (LDI1 source)
//   IN2  data input B (LDI2 source)
//   OUT0 output-port register, OUT1 accumulator R0, OUT2 {halted,Z,N,C,icount}
interface main_cpu_if;

  logic [main_cpu_pkg::DATA_W-1:0] IN0;
  logic [main_cpu_pkg::DATA_W-1:0] IN1;
  logic [main_cpu_pkg::DATA_W-1:0] IN2;
  logic [main_cpu_pkg::DATA_W-1:0] OUT0;
  logic [main_cpu_pkg::DATA_W-1:0] OUT1;
  logic [main_cpu_pkg::DATA_W-1:0] OUT2;

  // Driver side (board / testbench).
  modport master (
    output IN0, IN1, IN2,
    input  OUT0, OUT1, OUT2
  );

  // CPU side.
  modport slave (
    input  IN0, IN1, IN2,
    output OUT0, OUT1, OUT2
  );

endinterface

// File: rtl/main_cpu_alu.sv
// Combinational ALU for main_cpu.
//   i_a        rd operand (destination's current value)
//   i_b        source operand (R[rs], or IN1/IN2 for the load opcodes)
//   i_op       opcode
//   o_result_c result to write back
//   o_c_out_c  carry / borrow / shifted-out bit
//   o_c_upd_c  high when the opcode updates the C flag
module main_cpu_alu
  import main_cpu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [OP_W-1:0]   i_op,
  output logic [DATA_W-1:0] o_result_c,
  output logic              o_c_out_c,
  output logic              o_c_upd_c
);

  // One extra bit captures carry-out on add and borrow on subtract.
  logic [DATA_W:0] w_wide;

  always_comb begin
    o_result_c = '0;
    o_c_out_c  = 1'b0;
    o_c_upd_c  = 1'b0;
    w_wide     = '0;
    case (i_op)
      OP_LDI1, OP_LDI2, OP_MOV: o_result_c = i_b;
      OP_ADD: begin
        w_wide     = {1'b0, i_a} + {1'b0, i_b};
        o_result_c = w_wide[DATA_W-1:0];
        o_c_out_c  = w_wide[DATA_W];
        o_c_upd_c  = 1'b1;
      end
      OP_SUB: begin
        w_wide     = {1'b0, i_a} - {1'b0, i_b};
        o_result_c = w_wide[DATA_W-1:0];
        o_c_out_c  = w_wide[DATA_W];
        o_c_upd_c  = 1'b1;
      end
      OP_AND: o_result_c = i_a & i_b;
      OP_OR:  o_result_c = i_a | i_b;
      OP_XOR: o_result_c = i_a ^ i_b;
      OP_NOT: o_result_c = ~i_b;
      OP_SHL: begin
        o_result_c = {i_b[DATA_W-2:0], 1'b0};
        o_c_out_c  = i_b[DATA_W-1];
        o_c_upd_c  = 1'b1;
      end
      OP_SHR: begin
        o_result_c = {1'b0, i_b[DATA_W-1:1]};
        o_c_out_c  = i_b[0];
        o_c_upd_c  = 1'b1;
      end
      OP_INC: begin
        w_wide     = {1'b0, i_a} + (DATA_W+1)'(1);
        o_result_c = w_wide[DATA_W-1:0];
        o_c_out_c  = w_wide[DATA_W];
        o_c_upd_c  = 1'b1;
      end
      OP_DEC: begin
        w_wide     = {1'b0, i_a} - (DATA_W+1)'(1);
        o_result_c = w_wide[DATA_W-1:0];
        o_c_out_c  = w_wide[DATA_W];
        o_c_upd_c  = 1'b1;
      end
      OP_NOP, OP_OUT, OP_HALT: o_result_c = '0;
      default: o_result_c = '0;
    endcase
  end

endmodule

// File: rtl/main_cpu.sv
// 8-bit single-cycle register CPU core: one instruction from IN0 per rising
// edge, results visible right after that edge.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears all state
//   bus    main_cpu_if slave: IN0/IN1/IN2 in, OUT0/OUT1/OUT2 out (all registered)
module main_cpu
  import main_cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  main_cpu_if.slave    bus
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   r_out_q;
  logic                r_z;
  logic                r_n;
  logic                r_c;
  logic                r_halted;
  logic [ICOUNT_W-1:0] r_icount;

  logic [OP_W-1:0]     w_op;
  logic [REG_AW-1:0]   w_rd;
  logic [REG_AW-1:0]   w_rs;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_result;
  logic                w_c_out;
  logic                w_c_upd;
  logic                w_wr;
  logic [DATA_W-1:0]   w_status;

  // Instruction decode.
  assign w_op = f_opcode(bus.IN0);
  assign w_rd = f_rd(bus.IN0);
  assign w_rs = f_rs(bus.IN0);
  assign w_wr = f_writes_reg(w_op);
  assign w_a  = r_regs[w_rd];

  // Loads route the external data inputs through the ALU's pass-through path.
  always_comb begin
    w_b = r_regs[w_rs];
    if (w_op == OP_LDI1) begin
      w_b = bus.IN1;
    end else if (w_op == OP_LDI2) begin
      w_b = bus.IN2;
    end
  end

  main_cpu_alu u_alu (
    .i_a        (w_a),
    .i_b        (w_b),
    .i_op       (w_op),
    .o_result_c (w_result),
    .o_c_out_c  (w_c_out),
    .o_c_upd_c  (w_c_upd)
  );

  // Architectural state; frozen entirely once halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
      r_out_q  <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_halted <= 1'b0;
      r_icount <= '0;
    end else if (!r_halted) begin
      r_icount <= r_icount + ICOUNT_W'(1);
      if (w_wr) begin
        r_regs[w_rd] <= w_result;
        r_z          <= (w_result == '0);
        r_n          <= w_result[DATA_W-1];
      end
      if (w_c_upd) begin
        r_c <= w_c_out;
      end
      if (w_op == OP_OUT) begin
        r_out_q <= r_regs[w_rs];
      end
      if (w_op == OP_HALT) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Status byte assembled from registered state only.
  always_comb begin
    w_status                 = '0;
    w_status[ICOUNT_W-1:0]   = r_icount;
    w_status[FLAG_C]         = r_c;
    w_status[FLAG_N]         = r_n;
    w_status[FLAG_Z]         = r_z;
    w_status[FLAG_HALT]      = r_halted;
  end

  assign bus.OUT0 = r_out_q;
  assign bus.OUT1 = r_regs[0];
  assign bus.OUT2 = w_status;

endmodule

// File: tb/tb_main_cpu.sv
// Randomized scoreboard bench for main_cpu against an arithmetic reference model.
module tb_main_cpu;

  logic clk;
  logic rst_n;

  main_cpu_if bus ();

  main_cpu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         tag;
    logic [7:0] o0;
    logic [7:0] o1;
    logic [7:0] o2;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model state.
  int m_r[4];
  int m_out, m_z, m_n, m_c, m_halt, m_ic;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, req, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_out = 0; m_z = 0; m_n = 0; m_c = 0; m_halt = 0; m_ic = 0;
  endtask

  task automatic model_step(input logic [7:0] instr, input logic [7:0] in1, input logic [7:0] in2);
    int op, rd, rs, a, b, res, wr;
    if (m_halt != 0) return;
    op = int'(instr) / 16;
    rd = (int'(instr) / 4) % 4;
    rs = int'(instr) % 4;
    a = m_r[rd];
    b = m_r[rs];
    wr = 1;
    res = 0;
    case (op)
      0:  wr = 0;
      1:  res = int'(in1);
      2:  res = int'(in2);
      3:  res = b;
      4:  begin res = a + b; m_c = (res > 255) ? 1 : 0; end
      5:  begin res = a - b; m_c = (a < b) ? 1 : 0; end
      6:  res = a & b;
      7:  res = a | b;
      8:  res = a ^ b;
      9:  res = 255 - b;
      10: begin res = b * 2; m_c = (b >= 128) ? 1 : 0; end
      11: begin res = b / 2; m_c = b % 2; end
      12: begin res = a + 1; m_c = (a == 255) ? 1 : 0; end
      13: begin res = a - 1; m_c = (a == 0) ? 1 : 0; end
      14: begin wr = 0; m_out = b; end
      default: begin wr = 0; m_halt = 1; end
    endcase
    res = ((res % 256) + 256) % 256;
    if (wr != 0) begin
      m_r[rd] = res;
      m_z = (res == 0) ? 1 : 0;
      m_n = (res >= 128) ? 1 : 0;
    end
    m_ic = (m_ic + 1) % 16;
  endtask

  function automatic exp_t model_expect(input int tag);
    exp_t e;
    e.tag = tag;
    e.o0 = 8'(m_out);
    e.o1 = 8'(m_r[0]);
    e.o2 = 8'(m_halt * 128 + m_z * 64 + m_n * 32 + m_c * 16 + m_ic);
    return e;
  endfunction

  // Drive one instruction at a falling edge; it executes on the next rising edge.
  task automatic exec(input logic [7:0] instr, input logic [7:0] in1, input logic [7:0] in2);
    @(negedge clk);
    bus.IN0 = instr;
    bus.IN1 = in1;
    bus.IN2 = in2;
    model_step(instr, in1, in2);
    q.push_back(model_expect(cyc + 1));
  endtask

  task automatic rand_exec(input bit allow_halt);
    logic [7:0] instr;
    instr = 8'($urandom_range(0, 255));
    if (instr[7:4] == 4'hF && !(allow_halt && $urandom_range(0, 7) == 0))
      instr[7:4] = 4'($urandom_range(0, 14));
    exec(instr, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  // Monitor: compare outputs against the expectation tagged for this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag < cyc) begin
      exp_t s;
      s = q.pop_front();
      n_checks++;
      $display("FAIL stale_expect: tag %0d never checked, now cycle %0d", s.tag, cyc);
    end
    if (q.size() > 0 && q[0].tag == cyc) begin
      exp_t e;
      e = q.pop_front();
      check("OUT0", bus.OUT0, e.o0);
      check("OUT1", bus.OUT1, e.o1);
      check("OUT2", bus.OUT2, e.o2);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.IN0 = '0;
    bus.IN1 = '0;
    bus.IN2 = '0;
    model_reset();

    // Reset held with random instructions: outputs stay zero.
    repeat (4) begin
      @(negedge clk);
      bus.IN0 = 8'($urandom_range(0, 255));
      bus.IN1 = 8'($urandom_range(0, 255));
      q.push_back(model_expect(cyc + 1));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load/add.
    exec(8'h10, 8'h05, 8'h00);
    exec(8'h24, 8'h00, 8'h03);
    exec(8'h41, 8'h00, 8'h00);

    // Wrap on ADD, borrow on SUB.
    exec(8'h10, 8'hFF, 8'h00);
    exec(8'h14, 8'h01, 8'h00);
    exec(8'h41, 8'h00, 8'h00);
    exec(8'h10, 8'h03, 8'h00);
    exec(8'h14, 8'h05, 8'h00);
    exec(8'h51, 8'h00, 8'h00);

    // Output port and shift.
    exec(8'h14, 8'h03, 8'h00);
    exec(8'hE1, 8'h00, 8'h00);
    exec(8'h31, 8'h00, 8'h00);
    exec(8'hA0, 8'h00, 8'h00);

    // rd==rs, INC/DEC boundaries, SHR carry.
    exec(8'h15, 8'h81, 8'h00);
    exec(8'h45, 8'h00, 8'h00);
    exec(8'h18, 8'hFF, 8'h00);
    exec(8'hC8, 8'h00, 8'h00);
    exec(8'hD8, 8'h00, 8'h00);
    exec(8'hB1, 8'h00, 8'h00);
    exec(8'hE2, 8'h00, 8'h00);

    // Random instruction stream without halts.
    repeat (300) rand_exec(1'b0);

    // Halt then ignored instructions.
    exec(8'hF0, 8'h00, 8'h00);
    repeat (3) exec(8'h10, 8'hAA, 8'h55);

    // Async reset pulse between edges while halted; the instruction already
    // on the bus executes on the next edge.
    @(negedge clk);
    bus.IN0 = 8'h10;
    bus.IN1 = 8'h5A;
    bus.IN2 = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    check("async_OUT0", bus.OUT0, 8'h00);
    check("async_OUT1", bus.OUT1, 8'h00);
    check("async_OUT2", bus.OUT2, 8'h00);
    #1 rst_n = 1'b1;
    model_reset();
    model_step(8'h10, 8'h5A, 8'h00);
    q.push_back(model_expect(cyc + 1));

    // Random stream after restart, occasional halts allowed.
    repeat (200) rand_exec(1'b1);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
